// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response bundle between the EX stage and the multicycle ALU
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             illegal_o;
  modport master (output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
                  input ready_o, busy_o, done_o, data_o, zero_o, illegal_o);
  modport slave (input valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
                 output ready_o, busy_o, done_o, data_o, zero_o, illegal_o);
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle add/sub/and/or plus an iterative shift-add multiply with flush
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_multicycle_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b010, OP_SUB = 3'b110, OP_AND = 3'b000, OP_OR = 3'b001, OP_MUL = 3'b111;
  logic [0:0]       state;
  logic [WIDTH-1:0] mcand, mplier, acc, data, res, acc_next;
  logic [CW-1:0]    cnt;
  logic             done, zero, illegal, accept, legal;
  assign accept   = bus.valid_i && state == IDLE && !bus.flush_i;
  assign legal    = bus.ALUCtrl_i inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign res      = bus.ALUCtrl_i == OP_ADD ? bus.data1_i + bus.data2_i :
                    bus.ALUCtrl_i == OP_SUB ? bus.data1_i - bus.data2_i :
                    bus.ALUCtrl_i == OP_AND ? bus.data1_i & bus.data2_i :
                    bus.ALUCtrl_i == OP_OR  ? bus.data1_i | bus.data2_i : '0;
  assign acc_next = mplier[0] ? acc + mcand : acc;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      data    <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (state == IDLE) begin
        if (accept && bus.ALUCtrl_i == OP_MUL) begin
          mcand  <= bus.data1_i;
          mplier <= bus.data2_i;
          acc    <= '0;
          cnt    <= '0;
          state  <= MUL;
        end else if (accept) begin
          data    <= res;
          zero    <= res == '0;
          done    <= 1'b1;
          illegal <= !legal;
        end
      end else if (bus.flush_i) begin
        state <= IDLE;
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // Final iteration publishes the accumulator including this cycle's partial product
        if (cnt == CW'(WIDTH - 1)) begin
          data  <= acc_next;
          zero  <= acc_next == '0;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
  assign bus.ready_o   = state == IDLE;
  assign bus.busy_o    = state != IDLE;
  assign bus.done_o    = done;
  assign bus.data_o    = data;
  assign bus.zero_o    = zero;
  assign bus.illegal_o = illegal;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors with hand-computed results for alu_multicycle
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  alu_multicycle_if #(.WIDTH(32)) bus ();
  alu_multicycle #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i   = v;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int done_at = 0;
    drive(1'b1, 3'b111, a, b);
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      if (bus.done_o) done_at = n;
    end
    chk({tag, "_lat"}, 64'(done_at), 64'd33);
    chk({tag, "_data"}, 64'(bus.data_o), 64'(exp));
    chk({tag, "_zero"}, 64'(bus.zero_o), 64'(exp == 0));
  endtask
  initial begin
    int busy_cnt, done_at, seen;
    logic [31:0] data_hold;
    drive(1'b0, 3'b010, 0, 0);
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_data", 64'(bus.data_o), 64'd0);
    chk("rst_zero", 64'(bus.zero_o), 64'd1);
    chk("rst_ill", 64'(bus.illegal_o), 64'd0);
    drive(1'b1, 3'b010, 32'h5, 32'h3);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("add_done", 64'(bus.done_o), 64'd1);
    chk("add_data", 64'(bus.data_o), 64'h8);
    chk("add_zero", 64'(bus.zero_o), 64'd0);
    chk("add_ready", 64'(bus.ready_o), 64'd1);
    chk("add_ill", 64'(bus.illegal_o), 64'd0);
    @(negedge clk);
    chk("add_pulse", 64'(bus.done_o), 64'd0);
    drive(1'b1, 3'b110, 32'd7, 32'd7);
    @(negedge clk);
    chk("sub1_done", 64'(bus.done_o), 64'd1);
    chk("sub1_data", 64'(bus.data_o), 64'h0);
    chk("sub1_zero", 64'(bus.zero_o), 64'd1);
    drive(1'b1, 3'b110, 32'd0, 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("sub2_done", 64'(bus.done_o), 64'd1);
    chk("sub2_data", 64'(bus.data_o), 64'hFFFFFFFF);
    chk("sub2_zero", 64'(bus.zero_o), 64'd0);
    drive(1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    @(negedge clk);
    chk("and_data", 64'(bus.data_o), 64'h00F0_1200);
    drive(1'b1, 3'b001, 32'hF000_0001, 32'h0000_0F00);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("or_data", 64'(bus.data_o), 64'hF000_0F01);
    // Multiply with an add held on valid_i: must wait for the done cycle
    drive(1'b1, 3'b111, 32'hFFFFFFFF, 32'h3);
    busy_cnt = 0;
    done_at = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) drive(1'b1, 3'b010, 32'd1, 32'd1);
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) done_at = n;
    end
    chk("mul1_busy", 64'(busy_cnt), 64'd32);
    chk("mul1_lat", 64'(done_at), 64'd33);
    chk("mul1_data", 64'(bus.data_o), 64'hFFFFFFFD);
    chk("mul1_ready", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("b2b_done", 64'(bus.done_o), 64'd1);
    chk("b2b_data", 64'(bus.data_o), 64'd2);
    mul_op("mul_wrap", 32'h0001_0000, 32'h0001_0000, 32'h0);
    mul_op("mul_1234", 32'h1234, 32'h10, 32'h0001_2340);
    // Flush mid-multiply
    drive(1'b1, 3'b111, 32'd3, 32'd5);
    repeat (9) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_ready", 64'(bus.ready_o), 64'd1);
    chk("flush_data", 64'(bus.data_o), 64'h0001_2340);
    seen = 0;
    repeat (40) begin
      if (bus.done_o) seen++;
      @(negedge clk);
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    // Reset mid-multiply
    drive(1'b1, 3'b111, 32'd3, 32'd5);
    repeat (5) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_data", 64'(bus.data_o), 64'd0);
    chk("rstm_zero", 64'(bus.zero_o), 64'd1);
    chk("rstm_ready", 64'(bus.ready_o), 64'd1);
    seen = 0;
    repeat (40) begin
      if (bus.done_o) seen++;
      @(negedge clk);
    end
    chk("rstm_nodone", 64'(seen), 64'd0);
    // Illegal code after a nonzero result
    drive(1'b1, 3'b010, 32'd9, 32'd1);
    @(negedge clk);
    drive(1'b1, 3'b011, 32'd9, 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("ill_done", 64'(bus.done_o), 64'd1);
    chk("ill_flag", 64'(bus.illegal_o), 64'd1);
    chk("ill_data", 64'(bus.data_o), 64'd0);
    chk("ill_zero", 64'(bus.zero_o), 64'd1);
    @(negedge clk);
    chk("ill_pulse", 64'(bus.illegal_o), 64'd0);
    drive(1'b1, 3'b010, 32'd4, 32'd4);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("fidle_done", 64'(bus.done_o), 64'd0);
    chk("fidle_data", 64'(bus.data_o), 64'd0);
    chk("fidle_ready", 64'(bus.ready_o), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
